// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised data RAM
// and its clear sequencer.
package mem_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam logic [63:0] CLEAR_DEF = 64'h0;

  // Pointer width for n words; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_ram_array.sv
// Single write port storage with a synchronous,
// write-first read register.
module mem_ram_array
  import mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              zero_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (re_i) begin
      if (zero_i)
        q_q <= '0;
      else if (we_i && waddr_i == raddr_i)
        q_q <= wdata_i;
      else
        q_q <= mem_q[raddr_i];
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_ram_ctl.sv
// Data RAM controller: clear sweep FSM, range check,
// user/sweep port muxing and read-valid flag.
module mem_ram_ctl
  import mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter logic [DATA_W-1:0] CLEAR_VAL =
    CLEAR_DEF[DATA_W-1:0]
) (
  input  logic              CLOCK,
  input  logic              Init,
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] Address,
  input  logic              WE,
  input  logic              RE,
  input  logic              Clear,
  output logic [DATA_W-1:0] Q,
  output logic              Valid,
  output logic              Busy
);

  localparam int PW = clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic              in_rng;
  logic              mem_we, mem_re;
  logic [PW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;

  assign in_rng = {1'b0, Address} < LIM;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    waddr   = Address[PW-1:0];
    wdata   = D;
    unique case (state_q)
      SWEEP: begin
        mem_we = 1'b1;
        waddr  = ptr_q;
        wdata  = CLEAR_VAL;
        if (Clear) begin
          ptr_d = '0;
        end else if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PW'(1);
        end
      end
      IDLE: begin
        // Clear wins over any access in the same cycle.
        if (Clear) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end else begin
          mem_we  = WE && in_rng;
          mem_re  = RE;
          valid_d = RE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or posedge Init) begin
    if (Init) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  mem_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_array (
    .clk_i   (CLOCK),
    .rst_i   (Init),
    .we_i    (mem_we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (mem_re),
    .zero_i  (!in_rng),
    .raddr_i (Address[PW-1:0]),
    .q_o     (Q)
  );

  assign Valid = valid_q;
  assign Busy  = (state_q == SWEEP);

endmodule

// File: tb/tb_mem_ram_ctl.sv
// Bench for mem_ram_ctl: directed checks plus random
// traffic against a behavioural memory model.
module tb_mem_ram_ctl;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 20;
  localparam logic [7:0] CV = 8'hA5;

  logic          CLOCK = 1'b0;
  logic          Init;
  logic [DW-1:0] D;
  logic [AW-1:0] Address;
  logic          WE, RE, Clear;
  logic [DW-1:0] Q;
  logic          Valid, Busy;

  mem_ram_ctl #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .DEPTH     (DEPTH),
    .CLEAR_VAL (CV)
  ) dut (
    .CLOCK   (CLOCK),
    .Init    (Init),
    .D       (D),
    .Address (Address),
    .WE      (WE),
    .RE      (RE),
    .Clear   (Clear),
    .Q       (Q),
    .Valid   (Valid),
    .Busy    (Busy)
  );

  always #5 CLOCK = ~CLOCK;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: memory array, busy flag, sweep position.
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_q;
  bit         m_v;
  bit         m_busy;
  int         m_pos;

  always @(posedge CLOCK or posedge Init) begin
    if (Init) begin
      m_q = 8'h0;
      m_v = 1'b0;
      m_busy = 1'b1;
      m_pos = 0;
    end else if (m_busy) begin
      m_v = 1'b0;
      m_mem[m_pos] = CV;
      if (Clear) begin
        m_pos = 0;
      end else begin
        m_pos++;
        if (m_pos == DEPTH) begin
          m_busy = 1'b0;
          m_pos = 0;
        end
      end
    end else if (Clear) begin
      m_busy = 1'b1;
      m_pos = 0;
      m_v = 1'b0;
    end else begin
      if (WE && int'(Address) < DEPTH)
        m_mem[Address] = D;
      if (RE) begin
        if (int'(Address) < DEPTH) m_q = m_mem[Address];
        else m_q = 8'h0;
        m_v = 1'b1;
      end else begin
        m_v = 1'b0;
      end
    end
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge CLOCK) begin
    if (cmp_en) begin
      check("model_q", 64'(Q), 64'(m_q));
      check("model_valid", 64'(Valid), 64'(m_v));
      check("model_busy", 64'(Busy), 64'(m_busy));
    end
  end

  task automatic step(input bit we, input bit re,
                      input bit clr, input int a,
                      input logic [7:0] d);
    WE = we;
    RE = re;
    Clear = clr;
    Address = AW'(a);
    D = d;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic sweep_len(input string nm);
    int n;
    n = 0;
    while (Busy && n < 100) begin
      step(0, 0, 0, 0, 8'h0);
      n++;
    end
    check(nm, 64'(n), 64'(DEPTH));
  endtask

  int cnt;

  initial begin
    Init = 1'b1;
    WE = 0;
    RE = 0;
    Clear = 0;
    Address = '0;
    D = '0;
    repeat (2) @(posedge CLOCK);
    #1;
    check("rst_q", 64'(Q), 64'h0);
    check("rst_valid", 64'(Valid), 64'h0);
    check("rst_busy", 64'(Busy), 64'h1);
    Init = 1'b0;
    cmp_en = 1'b1;
    sweep_len("init_sweep_len");

    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0, i, 8'h0);
      check("sweep_q", 64'(Q), 64'hA5);
      check("sweep_valid", 64'(Valid), 64'h1);
    end

    step(1, 0, 0, 7, 8'h3C);
    step(0, 1, 0, 7, 8'h0);
    check("wr_rd_q", 64'(Q), 64'h3C);
    check("wr_rd_model", 64'(m_q), 64'h3C);
    check("wr_rd_valid", 64'(Valid), 64'h1);

    step(1, 1, 0, 12, 8'h81);
    check("wfirst_q", 64'(Q), 64'h81);

    step(1, 0, 0, 25, 8'hFF);
    step(0, 1, 0, 25, 8'h0);
    check("oor_q", 64'(Q), 64'h0);
    check("oor_valid", 64'(Valid), 64'h1);
    step(0, 1, 0, 19, 8'h0);
    check("edge19_q", 64'(Q), 64'hA5);
    step(0, 0, 0, 0, 8'h0);
    check("valid_drop", 64'(Valid), 64'h0);

    step(1, 0, 1, 3, 8'h11);
    cnt = Busy ? 1 : 0;
    for (int k = 1; k < 100; k++) begin
      step(0, 0, k == 10, 0, 8'h0);
      if (Busy) cnt++;
      else break;
    end
    check("clr_busy_len", 64'(cnt), 64'(10 + DEPTH));
    step(0, 1, 0, 3, 8'h0);
    check("clr_drop_q", 64'(Q), 64'hA5);

    repeat (400) begin
      step($urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 49) == 0,
           int'($urandom_range(0, 31)),
           8'($urandom));
    end

    cnt = 0;
    while (Busy && cnt < 100) begin
      step(0, 0, 0, 0, 8'h0);
      cnt++;
    end
    check("idle_wait", 64'(Busy), 64'h0);

    step(1, 0, 0, 5, 8'h5A);
    step(0, 1, 0, 5, 8'h0);
    check("pre_rst_q", 64'(Q), 64'h5A);
    RE = 1'b1;
    Address = 5'd5;
    #2;
    Init = 1'b1;
    #1;
    check("midrd_q", 64'(Q), 64'h0);
    check("midrd_valid", 64'(Valid), 64'h0);
    check("midrd_busy", 64'(Busy), 64'h1);
    RE = 1'b0;
    @(negedge CLOCK);
    Init = 1'b0;
    @(posedge CLOCK);
    #1;
    cnt = 1;
    while (Busy && cnt < 100) begin
      step(0, 0, 0, 0, 8'h0);
      cnt++;
    end
    check("rst2_sweep_len", 64'(cnt), 64'(DEPTH));
    step(0, 1, 0, 5, 8'h0);
    check("rst2_q", 64'(Q), 64'hA5);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
